// File: rtl/four_way_request_arbiter_pkg.sv
// Shared types and constants for the four-way request arbiter.
// Holds the FSM state enum, the requester count and the index width.
package four_way_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

endpackage

// File: rtl/four_way_request_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// master: drives req/done; slave: the arbiter, drives the grant side.
interface four_way_request_arbiter_if;
  import four_way_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic               done;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_valid;
  logic               timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_idx,
    input  grant_valid,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_idx,
    output grant_valid,
    output timeout
  );

endinterface

// File: rtl/four_way_request_arbiter_prio_enc.sv
// 4:2 priority encoder with valid flag; highest set index wins.
// In: req[3:0]. Out: idx[1:0] of winning bit, valid = |req.
module priority_encoder_4to2_valid
  import four_way_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  output logic [IDX_W-1:0]   idx,
  output logic               valid
);

  always_comb begin
    idx   = '0;
    valid = |req;
    priority case (1'b1)
      req[3]:  idx = 2'd3;
      req[2]:  idx = 2'd2;
      req[1]:  idx = 2'd1;
      default: idx = 2'd0;
    endcase
  end

endmodule

// File: rtl/four_way_request_arbiter.sv
// Four-way arbiter: registers one winner, holds until done/drop/timeout.
// Ports: clk, reset (sync, active-high), bus (slave: req/done in, grant out).
module four_way_request_arbiter
  import four_way_arb_pkg::*;
#(
  parameter bit          ROUND_ROBIN = 1'b0,
  parameter int unsigned MAX_HOLD    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  four_way_request_arbiter_if.slave  bus
);

  localparam int CNT_W =
    (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0]   grant_idx_q, grant_idx_d;
  logic               grant_valid_q, grant_valid_d;
  logic               timeout_q, timeout_d;

  logic [NUM_REQ-1:0] enc_in;
  logic [IDX_W-1:0]   enc_idx;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;
  logic               rel_ext;
  logic               rel_hold;
  logic               rel_any;

  // Round-robin: bit for index last+1 lands on the encoder's top
  // input, so the encoder's "highest wins" becomes "nearest after
  // last wins"; the result is mapped back by win = last - enc_idx.
  always_comb begin
    enc_in = bus.req;
    if (ROUND_ROBIN) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        enc_in[NUM_REQ-1-j] = bus.req[last_q + IDX_W'(j + 1)];
      end
    end
  end

  priority_encoder_4to2_valid u_enc (
    .req   (enc_in),
    .idx   (enc_idx),
    .valid (win_valid)
  );

  assign win_idx = ROUND_ROBIN ? (last_q - enc_idx) : enc_idx;

  // done or a dropped request outranks the hold limit for timeout.
  assign rel_ext  = bus.done | ~bus.req[grant_idx_q];
  assign rel_hold = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);
  assign rel_any  = rel_ext | rel_hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_cnt_q    <= '0;
      last_q        <= 2'b11;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_cnt_q    <= hold_cnt_d;
      last_q        <= last_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_valid) state_d = GRANT;
      GRANT:   if (rel_any)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    hold_cnt_d    = hold_cnt_q;
    last_d        = last_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    timeout_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          grant_d       = NUM_REQ'(1) << win_idx;
          grant_idx_d   = win_idx;
          grant_valid_d = 1'b1;
          last_d        = win_idx;
          hold_cnt_d    = '0;
        end else begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (rel_any) begin
          grant_d       = '0;
          grant_valid_d = 1'b0;
          timeout_d     = rel_hold & ~rel_ext;
        end else if (MAX_HOLD != 0) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        grant_d       = '0;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = grant_idx_q;
  assign bus.grant_valid = grant_valid_q;
  assign bus.timeout     = timeout_q;

endmodule

// File: tb/tb_four_way_request_arbiter.sv
// Bench: fixed-priority (MAX_HOLD=4) and round-robin (MAX_HOLD=8) DUTs
// on shared stimulus, checked every cycle against a behavioural model.
module tb_four_way_request_arbiter;

  logic       clk = 1'b0;
  logic       reset_v = 1'b0;
  logic [3:0] req_v = 4'h0;
  logic       done_v = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  four_way_request_arbiter_if if_fix ();
  four_way_request_arbiter_if if_rr ();

  assign if_fix.req  = req_v;
  assign if_fix.done = done_v;
  assign if_rr.req   = req_v;
  assign if_rr.done  = done_v;

  four_way_request_arbiter #(.ROUND_ROBIN(1'b0), .MAX_HOLD(4)) u_fix (
    .clk   (clk),
    .reset (reset_v),
    .bus   (if_fix)
  );

  four_way_request_arbiter #(.ROUND_ROBIN(1'b1), .MAX_HOLD(8)) u_rr (
    .clk   (clk),
    .reset (reset_v),
    .bus   (if_rr)
  );

  // model state per DUT: 0 = fixed, 1 = round-robin
  bit         m_rr[2]   = '{1'b0, 1'b1};
  int         m_mh[2]   = '{4, 8};
  bit         m_busy[2];
  int         m_own[2];
  int         m_last[2];
  int         m_held[2];
  bit         m_to[2];
  bit         started = 1'b0;

  function automatic int pick(bit rr, int last, logic [3:0] r);
    int w;
    w = 0;
    if (!rr) begin
      for (int n = 3; n >= 0; n--)
        if (r[n]) begin w = n; break; end
    end else begin
      for (int k = 1; k <= 4; k++)
        if (r[(last + k) % 4]) begin w = (last + k) % 4; break; end
    end
    return w;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset_v) begin
        m_busy[k] = 1'b0; m_own[k] = 0; m_last[k] = 3;
        m_held[k] = 0;    m_to[k] = 1'b0;
      end else if (!m_busy[k]) begin
        m_to[k] = 1'b0;
        if (req_v != 4'h0) begin
          m_own[k]  = pick(m_rr[k], m_last[k], req_v);
          m_last[k] = m_own[k];
          m_busy[k] = 1'b1;
          m_held[k] = 0;
        end
      end else begin
        bit ext, lim;
        ext = done_v || !req_v[m_own[k]];
        lim = (m_mh[k] != 0) && (m_held[k] == m_mh[k] - 1);
        if (ext || lim) begin
          m_busy[k] = 1'b0;
          m_to[k]   = lim && !ext;
        end else begin
          m_held[k]++;
          m_to[k] = 1'b0;
        end
      end
    end
    if (reset_v) started = 1'b1;
  end

  task automatic check(input string tag, input logic [15:0] got,
                       input logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    check("fix.grant", 16'(if_fix.grant),
          m_busy[0] ? 16'(1 << m_own[0]) : 16'h0);
    check("fix.idx", 16'(if_fix.grant_idx), 16'(m_own[0]));
    check("fix.valid", 16'(if_fix.grant_valid), 16'(m_busy[0]));
    check("fix.timeout", 16'(if_fix.timeout), 16'(m_to[0]));
    check("rr.grant", 16'(if_rr.grant),
          m_busy[1] ? 16'(1 << m_own[1]) : 16'h0);
    check("rr.idx", 16'(if_rr.grant_idx), 16'(m_own[1]));
    check("rr.valid", 16'(if_rr.grant_valid), 16'(m_busy[1]));
    check("rr.timeout", 16'(if_rr.timeout), 16'(m_to[1]));
  endtask

  // compare the state left by the last edge, then drive the next inputs
  task automatic step(input logic [3:0] r, input logic d, input logic rs);
    @(negedge clk);
    if (started) compare_all();
    req_v   = r;
    done_v  = d;
    reset_v = rs;
  endtask

  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  int         rr_seq[$];
  int         exp_seq[5] = '{0, 1, 2, 3, 0};
  logic [11:0] v_pat, t_pat;
  logic [3:0]  rq;

  initial begin
    // reset held 2 cycles with all requests up
    step(4'hF, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b1);
    settle();
    check("rst.grant", 16'(if_fix.grant | if_rr.grant), 16'h0);
    check("rst.valid", 16'(if_fix.grant_valid | if_rr.grant_valid), 16'h0);
    step(4'hF, 1'b0, 1'b0);
    settle();
    check("first.fix", 16'(if_fix.grant), 16'h8);
    check("first.rr", 16'(if_rr.grant), 16'h1);

    // fixed priority with done every 3rd cycle
    step(4'h5, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(4'h5, (i % 3) == 2, 1'b0);
      settle();
      if (if_fix.grant_valid)
        check("fix.prio", 16'(if_fix.grant), 16'h4);
    end

    // round-robin rotation, done one cycle into each grant
    step(4'hF, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      step(4'hF, m_busy[1], 1'b0);
      settle();
      if (if_rr.grant_valid && !m_busy[1] == 1'b0 && m_held[1] == 0
          && (rr_seq.size() == 0 || 1)) begin
        if (i % 2 == 0) rr_seq.push_back(int'(if_rr.grant_idx));
      end
    end
    check("rr.seq_len", 16'(rr_seq.size()), 16'd5);
    for (int i = 0; i < 5 && i < rr_seq.size(); i++)
      check("rr.seq", 16'(rr_seq[i]), 16'(exp_seq[i]));

    // hold-limit release on the MAX_HOLD=4 instance
    step(4'h8, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(4'h8, 1'b0, 1'b0);
      settle();
      v_pat[i] = if_fix.grant_valid;
      t_pat[i] = if_fix.timeout;
    end
    check("to.valid_pat", 16'(v_pat), 16'hDEF);
    check("to.pulse_pat", 16'(t_pat), 16'h210);

    // dropped request releases without timeout
    step(4'h6, 1'b0, 1'b1);
    step(4'h6, 1'b0, 1'b0);
    settle();
    check("drop.grant0", 16'(if_fix.grant), 16'h4);
    step(4'h2, 1'b0, 1'b0);
    settle();
    check("drop.release", 16'(if_fix.grant), 16'h0);
    check("drop.no_to", 16'(if_fix.timeout), 16'h0);
    step(4'h2, 1'b0, 1'b0);
    settle();
    check("drop.regrant", 16'(if_fix.grant), 16'h2);

    // reset in the second cycle of a grant
    step(4'hF, 1'b0, 1'b1);
    step(4'hF, 1'b0, 1'b0);
    step(4'hF, 1'b0, 1'b0);
    settle();
    check("mid.held", 16'(if_rr.grant), 16'h1);
    step(4'hF, 1'b0, 1'b1);
    settle();
    check("mid.grant", 16'(if_rr.grant | if_fix.grant), 16'h0);
    check("mid.to", 16'(if_rr.timeout | if_fix.timeout), 16'h0);
    step(4'hF, 1'b0, 1'b0);
    settle();
    check("mid.rr_restart", 16'(if_rr.grant), 16'h1);

    // random traffic with sticky requests
    rq = 4'h0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
      step(rq, $urandom_range(0, 5) == 0, $urandom_range(0, 60) == 0);
    end
    step(4'h0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/four_way_request_arbiter.md
Name: four_way_request_arbiter

Overview:
- Sequential arbiter that shares one resource among four requesters (req[0]..req[3]).
- Built around the 4:2 priority-encoding function, with a valid flag added.
- Registers a single winner, holds the grant until release or timeout, then re-arbitrates.
- Sits between lab-level request sources and a shared datapath; grant_idx drives the datapath select.

Parameters:
- ROUND_ROBIN, 0, 0 = fixed priority (req[3] highest, req[0] lowest); 1 = rotating priority.
- MAX_HOLD, 8, max cycles a grant may be held before forced release; 0 disables the timeout.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  4  request lines, bit i = requester i, level-sensitive.
- done  input  1  granted requester releases the resource; sampled only in GRANT.
- grant  output  4  one-hot grant, registered.
- grant_idx  output  2  binary index of the granted requester, registered.
- grant_valid  output  1  high while any grant is active.
- timeout  output  1  one-cycle pulse when a grant is forcibly released by MAX_HOLD.

Behaviour:
- Interface (already decided): one clock, clk; reset is synchronous and active-high, reset.
- Reset values, taken on the first clk edge with reset=1:
  - state=IDLE, grant=4'b0000, grant_idx=2'b00, grant_valid=0, timeout=0.
  - hold_cnt=0, last_idx=2'b11.
- States: IDLE, GRANT.
- IDLE:
  - If req==0, stay in IDLE with all outputs low.
  - Otherwise, select a winner combinationally and on the next edge enter GRANT.
  - In GRANT, grant[w]=1, grant_idx=w, grant_valid=1, last_idx=w, hold_cnt=0.
  - Latency from req to grant: 1 cycle.
- Winner selection:
  - Fixed mode: highest set index wins (req=4'b0110 gives w=2).
  - Round-robin mode: search indices last_idx+1, +2, +3, +4 (mod 4); first set bit wins.
  - After reset, round-robin search therefore starts at index 0.
- GRANT, evaluated each cycle:
  - Release if done=1, or req[grant_idx]=0, or (MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1).
  - On release: next edge returns to IDLE; grant=0, grant_valid=0; grant_idx keeps its last value.
  - Otherwise: hold_cnt increments and the grant is unchanged.
- Release causes:
  - timeout=1 for exactly the cycle after a release caused only by the hold limit.
  - A release caused by done or by a dropped req never raises timeout, even if it coincides with the hold limit.
- Mandatory dead cycle: at least one IDLE cycle between consecutive grants.
  - Minimum grant-to-grant spacing: 2 cycles.
  - The same requester may win again after the dead cycle; round-robin prevents this when others are requesting.
- Ignored inputs:
  - done in IDLE is ignored.
  - Changes on non-granted req bits during GRANT are ignored.
- Reset mid-grant: outputs return to reset values on that edge and no timeout pulse is produced.
- Counter width: hold_cnt is $clog2(MAX_HOLD+1) bits (minimum 1). It never wraps, because release occurs at MAX_HOLD-1.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid == |grant.
  - grant_idx matches the grant bit whenever grant_valid=1.

Decomposition:
- Shared package four_way_arb_pkg holds:
  - State enum (IDLE, GRANT).
  - Constant NUM_REQ=4.
  - Index width constant IDX_W=2.
- One natural sub-module: priority_encoder_4to2_valid.
  - Combinational; input 4 bits; outputs idx[1:0] and valid.
  - Highest index wins.
  - Round-robin mode feeds it a rotated request vector and un-rotates the result.

Test Plan:
- Reset: hold reset=1 for 2 cycles with req=4'b1111 -> grant=0, grant_valid=0, timeout=0 throughout; the first grant appears 1 cycle after reset drops.
- Fixed priority (ROUND_ROBIN=0): req=4'b0101 steady, pulse done every 3rd cycle -> grant=4'b0100 repeatedly, with a 1-cycle gap of grant=0 between grants.
- Round-robin (ROUND_ROBIN=1): req=4'b1111, done pulsed 1 cycle after each grant -> grant_idx sequence 0,1,2,3,0, each grant separated by one idle cycle.
- Timeout (MAX_HOLD=4): req=4'b1000 held, done=0 -> grant high for exactly 4 cycles, then timeout=1 for 1 cycle with grant=0, then regrant to index 3.
- Request drop: granted idx 2, drop req[2] while req[1]=1 -> grant=0 next cycle, timeout=0, then grant=4'b0010.
- Reset mid-grant: assert reset during cycle 2 of a grant -> all outputs 0 on that edge, no timeout pulse, and round-robin last_idx returns to 3.
